// File: rtl/cart_pkg.sv
// Shared types and constants for the 2600 cartridge bank-switch controller.
// Scheme encodings, loader force codes, hotspot bases and auto-detect size thresholds.
package cart_pkg;

    typedef enum logic [2:0] {
        BS_NONE2K = 3'd0,
        BS_NONE4K = 3'd1,
        BS_F8     = 3'd2,
        BS_F6     = 3'd3,
        BS_F4     = 3'd4,
        BS_FA     = 3'd5,
        BS_E0     = 3'd6,
        BS_F3F    = 3'd7
    } bs_mode_t;

    localparam logic [3:0] FBS_AUTO = 4'd0;
    localparam logic [3:0] FBS_F8   = 4'd1;
    localparam logic [3:0] FBS_F6   = 4'd2;
    localparam logic [3:0] FBS_E0   = 4'd4;
    localparam logic [3:0] FBS_3F   = 4'd5;
    localparam logic [3:0] FBS_F4   = 4'd6;
    localparam logic [3:0] FBS_FA   = 4'd8;

    localparam logic [12:0] HS_F8_BASE = 13'h1FF8;
    localparam logic [12:0] HS_F6_BASE = 13'h1FF6;
    localparam logic [12:0] HS_F4_BASE = 13'h1FF4;
    localparam logic [12:0] HS_FA_BASE = 13'h1FF8;
    localparam logic [12:0] HS_E0_BASE = 13'h1FE0;

    localparam logic [16:0] SZ_2K  = 17'd2048;
    localparam logic [16:0] SZ_4K  = 17'd4096;
    localparam logic [16:0] SZ_8K  = 17'd8192;
    localparam logic [16:0] SZ_12K = 17'd12288;
    localparam logic [16:0] SZ_16K = 17'd16384;
    localparam logic [16:0] SZ_32K = 17'd32768;

    function automatic bs_mode_t auto_mode(input logic [16:0] size);
        bs_mode_t m;
        if (size <= SZ_2K)        m = BS_NONE2K;
        else if (size <= SZ_4K)   m = BS_NONE4K;
        else if (size == SZ_8K)   m = BS_F8;
        else if (size == SZ_12K)  m = BS_FA;
        else if (size == SZ_16K)  m = BS_F6;
        else if (size == SZ_32K)  m = BS_F4;
        else                      m = BS_NONE4K;
        return m;
    endfunction

    // Power-up bank of each scheme is its last 4 KB bank, where the reset vector lives.
    function automatic logic [2:0] last_bank(input bs_mode_t mode);
        logic [2:0] b;
        case (mode)
            BS_F8:   b = 3'd1;
            BS_F6:   b = 3'd3;
            BS_F4:   b = 3'd7;
            BS_FA:   b = 3'd2;
            default: b = 3'd0;
        endcase
        return b;
    endfunction

    // 3F bank-number mask; also the index of the last 2 KB bank of the image.
    function automatic logic [3:0] bank_mask_3f(input logic [16:0] size);
        logic [3:0] m;
        if (size <= SZ_2K)       m = 4'd0;
        else if (size <= SZ_4K)  m = 4'd1;
        else if (size <= SZ_8K)  m = 4'd3;
        else if (size <= SZ_16K) m = 4'd7;
        else                     m = 4'd15;
        return m;
    endfunction

endpackage

// File: rtl/cart_bank_ctrl_hotspot_dec.sv
// Combinational decode of the CPU address against the latched scheme:
// hotspot hits, E0 slice loads, 3F bank writes and extra-RAM port selects.
module cart_hotspot_dec
    import cart_pkg::*;
(
    input  logic [2:0]  i_mode,
    input  logic        i_sc,
    input  logic [12:0] i_cpu_a,
    input  logic        i_cpu_we,
    output logic        o_hit,
    output logic [2:0]  o_bank,
    output logic        o_e0_hit,
    output logic [1:0]  o_e0_slot,
    output logic [2:0]  o_e0_slice,
    output logic        o_lo_wr,
    output logic        o_ram_wr,
    output logic        o_ram_rd,
    output logic [7:0]  o_ram_a
);

    bs_mode_t    w_mode;
    logic [12:0] w_base;
    logic [12:0] w_cnt;
    logic [12:0] w_off;
    logic [12:0] w_e0_off;
    logic        w_sc_act;

    assign w_mode   = bs_mode_t'(i_mode);
    assign w_off    = i_cpu_a - w_base;
    assign w_e0_off = i_cpu_a - HS_E0_BASE;
    assign w_sc_act = i_sc && (w_mode == BS_F8 || w_mode == BS_F6 || w_mode == BS_F4);

    always_comb begin
        w_base = HS_F8_BASE;
        w_cnt  = 13'd0;
        case (w_mode)
            BS_F8:   begin w_base = HS_F8_BASE; w_cnt = 13'd2; end
            BS_F6:   begin w_base = HS_F6_BASE; w_cnt = 13'd4; end
            BS_F4:   begin w_base = HS_F4_BASE; w_cnt = 13'd8; end
            BS_FA:   begin w_base = HS_FA_BASE; w_cnt = 13'd3; end
            default: begin w_base = HS_F8_BASE; w_cnt = 13'd0; end
        endcase
    end

    always_comb begin
        o_hit      = (i_cpu_a >= w_base) && (w_off < w_cnt);
        o_bank     = w_off[2:0];
        // E0 hotspots cover slots 0..2 only; 1FF8..1FFF falls in fixed slot 3.
        o_e0_hit   = (w_mode == BS_E0) && (i_cpu_a >= HS_E0_BASE) && (w_e0_off < 13'd24);
        o_e0_slot  = w_e0_off[4:3];
        o_e0_slice = w_e0_off[2:0];
        o_lo_wr    = (w_mode == BS_F3F) && i_cpu_we && (i_cpu_a <= 13'h003F);
        o_ram_wr   = 1'b0;
        o_ram_rd   = 1'b0;
        o_ram_a    = 8'h00;
        if (i_cpu_a[12]) begin
            if (w_sc_act) begin
                if (i_cpu_a[11:7] == 5'd0) begin
                    o_ram_wr = i_cpu_we;
                    o_ram_a  = {1'b0, i_cpu_a[6:0]};
                end else if (i_cpu_a[11:7] == 5'd1) begin
                    o_ram_rd = !i_cpu_we;
                    o_ram_a  = {1'b0, i_cpu_a[6:0]};
                end
            end else if (w_mode == BS_FA) begin
                if (i_cpu_a[11:8] == 4'd0) begin
                    o_ram_wr = i_cpu_we;
                    o_ram_a  = i_cpu_a[7:0];
                end else if (i_cpu_a[11:8] == 4'd1) begin
                    o_ram_rd = !i_cpu_we;
                    o_ram_a  = i_cpu_a[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/cart_bank_ctrl.sv
// Cartridge bank-switch controller: latches the scheme from the loader, tracks
// hotspot writes/reads and forms the ROM byte address and extra-RAM port controls.
module cart_bank_ctrl
    import cart_pkg::*;
#(
    parameter int ROM_AW = 15,
    parameter int RAM_AW = 8
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cfg_ld,
    input  logic [3:0]        i_force_bs,
    input  logic              i_sc,
    input  logic [16:0]       i_rom_size,
    input  logic              i_cpu_ce,
    input  logic [12:0]       i_cpu_a,
    input  logic              i_cpu_we,
    input  logic [7:0]        i_cpu_di,
    output logic [ROM_AW-1:0] o_rom_a,
    output logic              o_ram_we,
    output logic              o_ram_re,
    output logic [RAM_AW-1:0] o_ram_a,
    output logic              o_bs_unsup
);

    bs_mode_t    r_mode;
    logic        r_unsup;
    logic        r_sc;
    logic [3:0]  r_mask;
    logic [2:0]  r_bank;
    logic [3:0]  r_lo_bank;
    logic [14:0] r_rom_a;

    bs_mode_t    w_mode_new;
    logic        w_unsup_new;
    logic        w_hit;
    logic [2:0]  w_new_bank;
    logic        w_e0_hit;
    logic [1:0]  w_e0_slot;
    logic [2:0]  w_e0_slice;
    logic        w_lo_wr;
    logic        w_ram_wr;
    logic        w_ram_rd;
    logic [7:0]  w_ram_a;
    logic [14:0] w_rom_map;
    logic [2:0]  w_slice [4];
    logic        w_unused;

    // 3F bank numbers are at most 4 bits, so the upper data bits never matter.
    assign w_unused = &{1'b0, i_cpu_di[7:4]};

    always_comb begin
        w_mode_new  = BS_NONE4K;
        w_unsup_new = 1'b0;
        case (i_force_bs)
            FBS_AUTO: w_mode_new = auto_mode(i_rom_size);
            FBS_F8:   w_mode_new = BS_F8;
            FBS_F6:   w_mode_new = BS_F6;
            FBS_E0:   w_mode_new = BS_E0;
            FBS_3F:   w_mode_new = BS_F3F;
            FBS_F4:   w_mode_new = BS_F4;
            FBS_FA:   w_mode_new = BS_FA;
            default:  w_unsup_new = 1'b1;
        endcase
    end

    cart_hotspot_dec u_dec (
        .i_mode     (r_mode),
        .i_sc       (r_sc),
        .i_cpu_a    (i_cpu_a),
        .i_cpu_we   (i_cpu_we),
        .o_hit      (w_hit),
        .o_bank     (w_new_bank),
        .o_e0_hit   (w_e0_hit),
        .o_e0_slot  (w_e0_slot),
        .o_e0_slice (w_e0_slice),
        .o_lo_wr    (w_lo_wr),
        .o_ram_wr   (w_ram_wr),
        .o_ram_rd   (w_ram_rd),
        .o_ram_a    (w_ram_a)
    );

    // A cfg_ld cycle takes priority over any hotspot hit in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mode    <= BS_NONE4K;
            r_unsup   <= 1'b0;
            r_sc      <= 1'b0;
            r_mask    <= 4'd0;
            r_bank    <= last_bank(BS_NONE4K);
            r_lo_bank <= 4'd0;
        end else if (i_cfg_ld) begin
            r_mode    <= w_mode_new;
            r_unsup   <= w_unsup_new;
            r_sc      <= i_sc && (w_mode_new == BS_F8 || w_mode_new == BS_F6 || w_mode_new == BS_F4);
            r_mask    <= bank_mask_3f(i_rom_size);
            r_bank    <= last_bank(w_mode_new);
            r_lo_bank <= 4'd0;
        end else if (i_cpu_ce) begin
            if (w_hit)
                r_bank <= w_new_bank;
            if (w_lo_wr)
                r_lo_bank <= i_cpu_di[3:0] & r_mask;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slice
            logic [2:0] r_slice;
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset)
                    r_slice <= 3'(4 + gi);
                else if (i_cfg_ld)
                    r_slice <= 3'(4 + gi);
                else if (i_cpu_ce && w_e0_hit && (w_e0_slot == 2'(gi)))
                    r_slice <= w_e0_slice;
            end
            assign w_slice[gi] = r_slice;
        end
    endgenerate
    assign w_slice[3] = 3'd7;

    always_comb begin
        w_rom_map = 15'd0;
        case (r_mode)
            BS_NONE2K: w_rom_map = {4'b0, i_cpu_a[10:0]};
            BS_NONE4K: w_rom_map = {3'b0, i_cpu_a[11:0]};
            BS_F8, BS_F6, BS_F4, BS_FA:
                       w_rom_map = {r_bank, i_cpu_a[11:0]};
            BS_E0:     w_rom_map = {2'b0, w_slice[i_cpu_a[11:10]], i_cpu_a[9:0]};
            BS_F3F:    w_rom_map = i_cpu_a[11] ? {r_mask, i_cpu_a[10:0]}
                                               : {r_lo_bank, i_cpu_a[10:0]};
            default:   w_rom_map = {3'b0, i_cpu_a[11:0]};
        endcase
    end

    // Keeps the last cartridge-space address so TIA/RIOT cycles leave rom_a stable.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_rom_a <= 15'd0;
        else if (i_cpu_a[12])
            r_rom_a <= w_rom_map;
    end

    assign o_rom_a    = i_cpu_a[12] ? w_rom_map : r_rom_a;
    assign o_ram_we   = w_ram_wr & i_cpu_ce;
    assign o_ram_re   = w_ram_rd;
    assign o_ram_a    = w_ram_a;
    assign o_bs_unsup = r_unsup;

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Self-checking bench for cart_bank_ctrl: expected bus results are queued as each
// cycle is driven and compared when the combinational outputs settle.
module tb_cart_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_ld;
    logic [3:0]  force_bs;
    logic        sc;
    logic [16:0] rom_size;
    logic        cpu_ce;
    logic [12:0] cpu_a;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic [14:0] rom_a;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_a;
    logic        bs_unsup;

    typedef struct {
        string       tag;
        logic [14:0] rom_a;
        logic        we;
        logic        re;
        logic [7:0]  ram_a;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [14:0] exp_hold = 15'd0;

    always #5 clk = ~clk;

    cart_bank_ctrl dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_cfg_ld   (cfg_ld),
        .i_force_bs (force_bs),
        .i_sc       (sc),
        .i_rom_size (rom_size),
        .i_cpu_ce   (cpu_ce),
        .i_cpu_a    (cpu_a),
        .i_cpu_we   (cpu_we),
        .i_cpu_di   (cpu_di),
        .o_rom_a    (rom_a),
        .o_ram_we   (ram_we),
        .o_ram_re   (ram_re),
        .o_ram_a    (ram_a),
        .o_bs_unsup (bs_unsup)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle; rom_a expectation for A12=0 is the last cartridge-space value.
    task automatic bus(input logic [12:0] a, input logic we, input logic [7:0] di, input logic ce,
                       input logic [14:0] erom, input logic ewe, input logic ere,
                       input logic [7:0] eram, input string tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        cpu_a  = a;
        cpu_we = we;
        cpu_di = di;
        cpu_ce = ce;
        e.tag   = tag;
        e.rom_a = a[12] ? erom : exp_hold;
        e.we    = ewe;
        e.re    = ere;
        e.ram_a = eram;
        if (a[12])
            exp_hold = erom;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk({g.tag, ".rom_a"},  32'(rom_a),  32'(g.rom_a));
        chk({g.tag, ".ram_we"}, 32'(ram_we), 32'(g.we));
        chk({g.tag, ".ram_re"}, 32'(ram_re), 32'(g.re));
        chk({g.tag, ".ram_a"},  32'(ram_a),  32'(g.ram_a));
        $display("txn %-14s a=%04h we=%0b ce=%0b rom_a=%04h ram_we=%0b ram_re=%0b ram_a=%02h",
                 tag, a, we, ce, rom_a, ram_we, ram_re, ram_a);
        @(posedge clk);
        #1;
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, input logic [14:0] erom, input string tag);
        bus(a, 1'b0, 8'h00, 1'b1, erom, 1'b0, 1'b0, 8'h00, tag);
    endtask

    task automatic cfg(input logic [3:0] fbs, input logic s, input logic [16:0] size,
                       input logic [12:0] a, input logic ce);
        @(negedge clk);
        cfg_ld   = 1'b1;
        force_bs = fbs;
        sc       = s;
        rom_size = size;
        cpu_a    = a;
        cpu_ce   = ce;
        cpu_we   = 1'b0;
        @(negedge clk);
        cfg_ld = 1'b0;
        cpu_ce = 1'b0;
        cpu_a  = 13'h0000;
        $display("cfg force_bs=%0d sc=%0b rom_size=%0d a=%04h ce=%0b", fbs, s, size, a, ce);
    endtask

    // Reset asserted between clock edges while a TIA cycle is on the bus.
    task automatic arst(input string tag);
        @(negedge clk);
        cpu_a  = 13'h0100;
        cpu_ce = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ".rom_a"},  32'(rom_a),    32'd0);
        chk({tag, ".unsup"},  32'(bs_unsup), 32'd0);
        $display("txn %-14s async reset rom_a=%04h", tag, rom_a);
        @(negedge clk);
        rst      = 1'b0;
        exp_hold = 15'd0;
    endtask

    initial begin
        rst = 1'b1; cfg_ld = 1'b0; force_bs = 4'd0; sc = 1'b0; rom_size = 17'd0;
        cpu_ce = 1'b0; cpu_a = 13'h0000; cpu_we = 1'b0; cpu_di = 8'h00;
        #7;
        chk("rst.rom_a",  32'(rom_a),    32'd0);
        chk("rst.ram_we", 32'(ram_we),   32'd0);
        chk("rst.ram_re", 32'(ram_re),   32'd0);
        chk("rst.unsup",  32'(bs_unsup), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(13'h1ABC, 15'h0ABC, "rst_none4k");

        // F8: hotspot read uses old bank, hold on A12=0, idempotence, ce qualification
        cfg(4'd1, 1'b0, 17'd8192, 13'h0000, 1'b0);
        rd(13'h1FF8, 15'h1FF8, "t1_hs");
        rd(13'h1123, 15'h0123, "t1_new");
        rd(13'h0080, 15'h0000, "t1_hold");
        rd(13'h1FF8, 15'h0FF8, "t1_idem");
        rd(13'h1456, 15'h0456, "t1_idem2");
        bus(13'h1FF9, 1'b0, 8'h00, 1'b0, 15'h0FF9, 1'b0, 1'b0, 8'h00, "t1_noce");
        rd(13'h1456, 15'h0456, "t1_noce2");
        cfg(4'd1, 1'b0, 17'd8192, 13'h1FF8, 1'b1);
        rd(13'h1000, 15'h1000, "t1_cfgwin");

        // F6 by auto-detect, async reset, re-latch
        cfg(4'd0, 1'b0, 17'd16384, 13'h0000, 1'b0);
        rd(13'h1FF7, 15'h3FF7, "t2_hs");
        rd(13'h1000, 15'h1000, "t2_new");
        arst("t2_arst");
        rd(13'h1000, 15'h0000, "t2_rst_none");
        cfg(4'd0, 1'b0, 17'd16384, 13'h0000, 1'b0);
        rd(13'h1000, 15'h3000, "t2_rst_bank");

        cfg(4'd0, 1'b0, 17'd2048,  13'h0000, 1'b0); rd(13'h1FFF, 15'h07FF, "auto2k");
        cfg(4'd0, 1'b0, 17'd4096,  13'h0000, 1'b0); rd(13'h1FFF, 15'h0FFF, "auto4k");
        cfg(4'd0, 1'b0, 17'd5000,  13'h0000, 1'b0); rd(13'h1FFF, 15'h0FFF, "auto_odd");
        cfg(4'd0, 1'b0, 17'd12288, 13'h0000, 1'b0); rd(13'h1234, 15'h2234, "auto12k");
        cfg(4'd0, 1'b0, 17'd32768, 13'h0000, 1'b0); rd(13'h1234, 15'h7234, "auto32k");
        cfg(4'd0, 1'b0, 17'd8192,  13'h0000, 1'b0); rd(13'h1234, 15'h1234, "auto8k");

        // SuperChip on F8
        cfg(4'd1, 1'b1, 17'd8192, 13'h0000, 1'b0);
        bus(13'h1005, 1'b1, 8'hAA, 1'b1, 15'h1005, 1'b1, 1'b0, 8'h05, "sc_wr");
        bus(13'h1085, 1'b0, 8'h00, 1'b1, 15'h1085, 1'b0, 1'b1, 8'h05, "sc_rd");
        bus(13'h1085, 1'b1, 8'h11, 1'b1, 15'h1085, 1'b0, 1'b0, 8'h05, "sc_rdport_wr");
        bus(13'h1005, 1'b0, 8'h00, 1'b1, 15'h1005, 1'b0, 1'b0, 8'h05, "sc_wrport_rd");
        bus(13'h1005, 1'b1, 8'h22, 1'b0, 15'h1005, 1'b0, 1'b0, 8'h05, "sc_noce");
        bus(13'h107F, 1'b1, 8'h33, 1'b1, 15'h107F, 1'b1, 1'b0, 8'h7F, "sc_top");
        rd(13'h1100, 15'h1100, "sc_out");

        // FA: 256 B RAM and three banks
        cfg(4'd8, 1'b1, 17'd12288, 13'h0000, 1'b0);
        bus(13'h10FF, 1'b1, 8'h5A, 1'b1, 15'h20FF, 1'b1, 1'b0, 8'hFF, "fa_wr");
        bus(13'h1101, 1'b0, 8'h00, 1'b1, 15'h2101, 1'b0, 1'b1, 8'h01, "fa_rd");
        rd(13'h1200, 15'h2200, "fa_out");
        rd(13'h1FF8, 15'h2FF8, "fa_hs");
        rd(13'h1200, 15'h0200, "fa_new");
        rd(13'h1FFA, 15'h0FFA, "fa_hs2");
        rd(13'h1200, 15'h2200, "fa_new2");
        rd(13'h1FFB, 15'h2FFB, "fa_nohs");
        rd(13'h1200, 15'h2200, "fa_nohs2");

        // E0: sc ignored, slice loads per slot, slot 3 fixed
        cfg(4'd4, 1'b1, 17'd8192, 13'h0000, 1'b0);
        bus(13'h1005, 1'b1, 8'h44, 1'b1, 15'h1005, 1'b0, 1'b0, 8'h00, "e0_nosc");
        rd(13'h1FE9, 15'h1FE9, "e0_hs1");
        rd(13'h1400, 15'h0400, "e0_slot1");
        rd(13'h1C00, 15'h1C00, "e0_slot3");
        rd(13'h1FF7, 15'h1FF7, "e0_hs2");
        rd(13'h1800, 15'h1C00, "e0_slot2");
        rd(13'h1FE3, 15'h1FE3, "e0_hs0");
        rd(13'h1000, 15'h0C00, "e0_slot0");
        rd(13'h1FF8, 15'h1FF8, "e0_nohs");
        rd(13'h1400, 15'h0400, "e0_nohs2");

        // 3F: writes below 0x40 select the lower 2 KB bank, masked by image size
        cfg(4'd5, 1'b0, 17'd8192, 13'h0000, 1'b0);
        rd(13'h1010, 15'h0010, "3f_lo0");
        bus(13'h003F, 1'b1, 8'h07, 1'b1, 15'h0000, 1'b0, 1'b0, 8'h00, "3f_wr7");
        rd(13'h1010, 15'h1810, "3f_lo3");
        rd(13'h1823, 15'h1823, "3f_hi");
        bus(13'h003E, 1'b1, 8'h01, 1'b1, 15'h0000, 1'b0, 1'b0, 8'h00, "3f_wr1");
        rd(13'h1010, 15'h0810, "3f_lo1");
        bus(13'h0040, 1'b1, 8'h02, 1'b1, 15'h0000, 1'b0, 1'b0, 8'h00, "3f_wr40");
        rd(13'h1010, 15'h0810, "3f_range");
        bus(13'h003F, 1'b0, 8'h02, 1'b1, 15'h0000, 1'b0, 1'b0, 8'h00, "3f_rd3f");
        rd(13'h1010, 15'h0810, "3f_rdnop");
        rd(13'h1810, 15'h1810, "3f_last");

        // F4, reset mid-cycle, unsupported scheme
        cfg(4'd6, 1'b0, 17'd32768, 13'h0000, 1'b0);
        rd(13'h1FF4, 15'h7FF4, "t6_hs");
        rd(13'h1234, 15'h0234, "t6_b0");
        arst("t6_arst");
        cfg(4'd6, 1'b0, 17'd32768, 13'h0000, 1'b0);
        rd(13'h1000, 15'h7000, "t6_rst");
        cfg(4'd3, 1'b0, 17'd8192, 13'h0000, 1'b0);
        chk("unsup_set", 32'(bs_unsup), 32'd1);
        rd(13'h1ABC, 15'h0ABC, "t6_unsup");
        rd(13'h1FF8, 15'h0FF8, "t6_unsup_hs");
        rd(13'h1800, 15'h0800, "t6_unsup_nohs");
        cfg(4'd1, 1'b0, 17'd8192, 13'h0000, 1'b0);
        chk("unsup_clr", 32'(bs_unsup), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
